// File: rtl/nn_pipe_pkg.sv
// Shared definitions for the neural-net pipeline controller.
// Holds the status encodings and the default sizing of the controller.
package nn_pipe_pkg;

    localparam int DEF_STAGES  = 3;
    localparam int DEF_STALL_W = 16;

    typedef enum logic [1:0] {
        PIPE_EMPTY   = 2'd0,
        PIPE_PARTIAL = 2'd1,
        PIPE_FULL    = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/nn_sat_counter.sv
// Saturating up-counter with a synchronous clear.
// Clear wins over increment. The count sticks at all-ones.
module nn_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/nn_pipe_ctrl.sv
// Valid/ready controller for a fixed-depth pipeline with one global stall.
// The pipeline stalls only when the last stage is blocked. Bubbles travel with the data and are never squeezed out.
module nn_pipe_ctrl
    import nn_pipe_pkg::*;
#(
    parameter int STAGES  = DEF_STAGES,
    parameter int STALL_W = DEF_STALL_W,
    localparam int CNT_W  = $clog2(STAGES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid,
    input  logic               ready_out,
    input  logic               flush,
    output logic               ready,
    output logic               valid_out,
    output logic [STAGES-1:0]  enable,
    output logic [CNT_W-1:0]   occupancy,
    output logic [1:0]         state,
    output logic [STALL_W-1:0] stall_cnt
);

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] vld_next;
    logic [CNT_W-1:0]  occ_next;
    logic              advance;
    logic              accept;
    logic              complete;
    logic              stall_inc;
    pipe_state_t       state_q;
    pipe_state_t       state_next;

    // The reset and flush terms keep the handshake and enables quiet in the cycle they are applied.
    always_comb begin
        advance   = !vld[STAGES-1] || ready_out;
        ready     = advance && !flush && !reset;
        accept    = valid && ready;
        valid_out = vld[STAGES-1] && !reset;
        complete  = valid_out && ready_out;
        stall_inc = valid_out && !ready_out;

        enable    = '0;
        enable[0] = accept;
        for (int i = 1; i < STAGES; i++) begin
            enable[i] = advance && vld[i-1] && !flush && !reset;
        end

        vld_next = vld;
        if (flush) begin
            vld_next = '0;
        end else if (advance) begin
            vld_next = {vld[STAGES-2:0], accept};
        end

        occ_next = flush ? '0 : (occupancy + CNT_W'(accept) - CNT_W'(complete));

        state_next = PIPE_PARTIAL;
        if (vld_next == '0) begin
            state_next = PIPE_EMPTY;
        end else if (&vld_next) begin
            state_next = PIPE_FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld       <= '0;
            occupancy <= '0;
            state_q   <= PIPE_EMPTY;
        end else begin
            vld       <= vld_next;
            occupancy <= occ_next;
            state_q   <= state_next;
        end
    end

    assign state = state_q;

    nn_sat_counter #(
        .WIDTH(STALL_W)
    ) u_stall_cnt (
        .clk  (clk),
        .inc  (stall_inc),
        .clr  (reset),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_nn_pipe_ctrl.sv
// Directed bench for nn_pipe_ctrl with 3 stages and a 4-bit stall counter.
// The scenarios are single item, streaming, backpressure, bubble, flush, and then saturation followed by a mid-stall reset.
module tb_nn_pipe_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid;
    logic       ready_out;
    logic       flush;
    logic       ready;
    logic       valid_out;
    logic [2:0] enable;
    logic [1:0] occupancy;
    logic [1:0] state;
    logic [3:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    nn_pipe_ctrl #(
        .STAGES (3),
        .STALL_W(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .valid    (valid),
        .ready_out(ready_out),
        .flush    (flush),
        .ready    (ready),
        .valid_out(valid_out),
        .enable   (enable),
        .occupancy(occupancy),
        .state    (state),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs change just after an edge, and checks run once the combinational logic has settled.
    task automatic apply_stimulus(input logic v, input logic ro, input logic fl, input logic rs);
        valid     = v;
        ready_out = ro;
        flush     = fl;
        reset     = rs;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1);
        step();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1);
        step();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exp_occ;
        int acc;
        int done;

        // Reset state
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
        check_output("rst_ready", ready, 0);
        check_output("rst_enable", enable, 0);
        check_output("rst_valid_out", valid_out, 0);
        step();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        check_output("rst_occ", occupancy, 0);
        check_output("rst_state", state, 0);
        check_output("rst_stall", stall_cnt, 0);
        check_output("rst_ready_after", ready, 1);

        // Single item
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
        check_output("single_en_t0", enable, 3'b001);
        check_output("single_ready_t0", ready, 1);
        step();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        check_output("single_en_t1", enable, 3'b010);
        check_output("single_occ_t1", occupancy, 1);
        check_output("single_vo_t1", valid_out, 0);
        step();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        check_output("single_en_t2", enable, 3'b100);
        check_output("single_occ_t2", occupancy, 1);
        check_output("single_vo_t2", valid_out, 0);
        step();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        check_output("single_vo_t3", valid_out, 1);
        check_output("single_en_t3", enable, 3'b000);
        check_output("single_occ_t3", occupancy, 1);
        step();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        check_output("single_vo_t4", valid_out, 0);
        check_output("single_occ_t4", occupancy, 0);
        check_output("single_state_t4", state, 0);

        // Streaming: ten items back to back, consumer always ready
        do_reset();
        for (int c = 0; c < 14; c++) begin
            apply_stimulus(c < 10, 1'b1, 1'b0, 1'b0);
            acc     = (c < 10) ? c : 10;
            done    = (c < 3) ? 0 : ((c - 3 > 10) ? 10 : c - 3);
            exp_occ = acc - done;
            check_output($sformatf("stream_ready_c%0d", c), ready, 1);
            check_output($sformatf("stream_vo_c%0d", c), valid_out, (c >= 3) && (c <= 12));
            check_output($sformatf("stream_occ_c%0d", c), occupancy, exp_occ);
            if (c == 6) begin
                check_output("stream_state_full", state, 2);
            end
            step();
        end
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        check_output("stream_stall", stall_cnt, 0);
        check_output("stream_state_end", state, 0);

        // Backpressure: fill, then stall five cycles
        do_reset();
        for (int c = 0; c < 3; c++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
            step();
        end
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        check_output("bp_occ_full", occupancy, 3);
        check_output("bp_state_full", state, 2);
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
            check_output($sformatf("bp_ready_k%0d", k), ready, 0);
            check_output($sformatf("bp_enable_k%0d", k), enable, 0);
            check_output($sformatf("bp_vo_k%0d", k), valid_out, 1);
            step();
        end
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
        check_output("bp_stall5", stall_cnt, 5);
        check_output("bp_release_ready", ready, 1);
        check_output("bp_release_enable", enable, 3'b111);
        check_output("bp_release_occ", occupancy, 3);
        step();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        check_output("bp_after_occ", occupancy, 3);
        check_output("bp_after_vo", valid_out, 1);
        check_output("bp_after_stall", stall_cnt, 5);

        // Bubble: item, idle, item, then block the output
        do_reset();
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
        step();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
            check_output($sformatf("bub_vld_k%0d", k), dut.vld, 3'b101);
            check_output($sformatf("bub_vo_k%0d", k), valid_out, 1);
            check_output($sformatf("bub_occ_k%0d", k), occupancy, 2);
            check_output($sformatf("bub_state_k%0d", k), state, 1);
            check_output($sformatf("bub_enable_k%0d", k), enable, 0);
            step();
        end

        // Flush with two items in flight and a pending input
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
        check_output("flush_ready", ready, 0);
        check_output("flush_enable", enable, 0);
        step();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        check_output("flush_occ", occupancy, 0);
        check_output("flush_vo", valid_out, 0);
        check_output("flush_state", state, 0);
        check_output("flush_stall_kept", stall_cnt, 3);

        // Saturation, then reset in the middle of the stall
        do_reset();
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
        step();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 20; k++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
            if (k == 15) begin
                check_output("sat_at15", stall_cnt, 15);
            end
            step();
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_output("sat_hold", stall_cnt, 15);
        check_output("sat_vo", valid_out, 1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1);
        check_output("midrst_vo", valid_out, 0);
        check_output("midrst_enable", enable, 0);
        check_output("midrst_ready", ready, 0);
        step();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        check_output("midrst_stall", stall_cnt, 0);
        check_output("midrst_state", state, 0);
        check_output("midrst_occ", occupancy, 0);
        check_output("midrst_ready_after", ready, 1);
        check_output("midrst_vo_after", valid_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nn_pipe_ctrl.md
NN_PIPE_CTRL -- requirements
Module: nn_pipe_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 3, number of pipeline register stages controlled (legal 2..8).
REQ-002 SHALL have parameter STALL_W, default 16, width of the stall-cycle counter (legal 4..32).
REQ-003 SHALL have derived constant CNT_W = clog2(STAGES+1), occupancy width.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port valid  input  1  feeder presents input data.
REQ-007 SHALL have port ready_out  input  1  consumer can take the result.
REQ-008 SHALL have port flush  input  1  synchronous discard of all in-flight items.
REQ-009 SHALL have port ready  output  1  controller accepts input this cycle.
REQ-010 SHALL have port valid_out  output  1  last stage holds a valid result.
REQ-011 SHALL have port enable  output  STAGES  per-stage register load enable; bit 0 is the input stage.
REQ-012 SHALL have port occupancy  output  CNT_W  number of valid items in flight.
REQ-013 SHALL have port state  output  2  pipeline status: EMPTY, PARTIAL or FULL.
REQ-014 SHALL have port stall_cnt  output  STALL_W  cycles spent with valid_out=1 and ready_out=0.

Function
REQ-015 SHALL keep an internal stage-valid vector vld[STAGES-1:0]; valid_out = vld[STAGES-1].
REQ-016 SHALL compute advance = !vld[STAGES-1] || ready_out (global stall, last stage only).
REQ-017 SHALL drive ready = advance && !flush && !reset, combinationally.
REQ-018 SHALL define accept = valid && ready.
REQ-019 SHALL drive enable[0] = accept and enable[i] = advance && vld[i-1] && !flush for i>0; enables load only stages that receive valid data.
REQ-020 SHALL, on advance without flush, set vld[0] <= accept and vld[i] <= vld[i-1]; otherwise SHALL hold vld.
REQ-021 SHALL meet this latency: an item accepted in cycle t asserts valid_out from cycle t+STAGES when unstalled.
REQ-022 SHALL treat a handshake as complete when valid_out && ready_out; valid_out SHALL NOT drop before completion except on flush/reset.
REQ-023 SHALL NOT compress bubbles: empty stages advance with the pipe and are held during a stall.
REQ-024 SHALL register occupancy, next = occupancy + accept - (valid_out && ready_out); simultaneous accept and completion leaves it unchanged; it SHALL always equal popcount(vld).
REQ-025 SHALL register state from next vld: EMPTY=0 if none set, FULL=2 if all set, PARTIAL=1 otherwise; encoding 3 unused.
REQ-026 SHALL, with flush=1, clear vld, occupancy and state (EMPTY) at the next edge; flush has priority over accept and completion; enable=0 and ready=0 in the flush cycle.
REQ-027 SHALL increment stall_cnt by 1 each cycle with valid_out && !ready_out, saturate at 2^STALL_W-1, and SHALL NOT clear it on flush.

Reset
REQ-028 SHALL, on reset, clear vld, occupancy, stall_cnt and state (EMPTY); valid_out=0 and enable=0 while reset is high.
REQ-029 SHALL, when reset is asserted mid-operation, discard all in-flight items with no output handshake.
REQ-030 SHALL have reset take priority over flush.
REQ-031 SHALL drive ready=1 in the first cycle after reset deasserts.

Structure
REQ-032 SHALL place the state encodings (EMPTY/PARTIAL/FULL) and the STAGES/STALL_W defaults in shared package nn_pipe_pkg.
REQ-033 SHALL implement stall_cnt in one sub-module nn_sat_counter (parameter width; inputs inc and clr; saturating); all other logic is inline.

Verification (STAGES=3 unless noted)
REQ-034 Single item: after reset, valid=1 for 1 cycle (t) with ready_out=1 -> enable[0] at t, enable[1] at t+1, enable[2] at t+2, valid_out for exactly cycle t+3; occupancy 1 in cycles t+1..t+3, then 0.
REQ-035 Streaming: 10 back-to-back items with ready_out=1 -> ready constant 1, valid_out cycles t+3..t+12, occupancy 3 and state FULL in steady state, stall_cnt 0.
REQ-036 Backpressure: fill to FULL, ready_out=0 for 5 cycles -> ready=0, enable=0, valid_out held, stall_cnt=5; on release, same-cycle accept and completion leave occupancy at 3.
REQ-037 Bubble: item, 1 idle cycle, item, then ready_out=0 when the first item reaches output -> vld=101 held unchanged, state PARTIAL, occupancy 2.
REQ-038 Flush: occupancy 2 with valid=1 and flush=1 -> ready=0 in that cycle, next cycle occupancy 0, valid_out 0, state EMPTY, stall_cnt retained.
REQ-039 Saturation/reset (STALL_W=4): hold a stall 20 cycles -> stall_cnt stops at 15; assert reset mid-stall -> stall_cnt 0, state EMPTY, ready=1 in the first cycle after release.
